adc_spi_responder: RTL and testbench
====================================

Name: adc_spi_responder

Overview:
- Synthesizable SPI slave that emulates the ADC end of the ADC SPI link.
- Receives SCLK, SYNC1 and SDI1 from the ADC_SPI_INTERFACE master and drives SDO1 back to it.
- Used for loopback and hardware-in-the-loop verification of the master without a physical ADC.
- Oversamples all SPI inputs on one system clock, shifts in a 16-bit command frame, and shifts out a tagged sample frame.

Parameters:
FRAME_W, 16, bits per SPI frame (SYNC1 low window)
DATA_W, 12, sample width; FRAME_W = 1 + CH_W + DATA_W
CH_W, 3, channel index width (8 channels)

Ports:
CLK  input  1  system clock; reset is asynchronous, active-low
RST_N  input  1  asynchronous active-low reset
SCLK  input  1  SPI clock from master, idle low (CPOL=0, CPHA=0)
SYNC1  input  1  active-low frame select from master
SDI1  input  1  serial command from master, MSB first
SDO1  output  1  serial sample data to master, MSB first
SAMPLE_IN  input  DATA_W  parallel sample for the channel on CH_SEL
CH_SEL  output  CH_W  currently selected conversion channel
CMD_OUT  output  FRAME_W  last valid received command word
CMD_VALID  output  1  one-CLK pulse when CMD_OUT updates
FRAME_ERR  output  1  one-CLK pulse on a malformed frame

Behaviour:
- Clocking requirement: CLK ≥ 8× SCLK.
- Input synchronisation: SCLK, SYNC1 and SDI1 each pass through a 2-flop synchronizer. Edges are detected on the synchronized copies only.
- Reset values: SDO1=0, CH_SEL=0, CMD_OUT=0, CMD_VALID=0, FRAME_ERR=0. Bit counter=0, state=WAIT_HIGH.
- FSM states:
  - WAIT_HIGH: stay until synced SYNC1=1, then go to IDLE. This prevents a frame already in progress at reset release from being accepted.
  - IDLE: SDO1=0. On a synced SYNC1 falling edge:
    - capture tx_shift = {1'b0, CH_SEL, SAMPLE_IN}, sampled on that CLK;
    - clear the bit counter and rx_shift;
    - go to SHIFT.
    - SDO1 presents tx_shift MSB no later than 3 CLK after the raw SYNC1 fall.
  - SHIFT, SCLK rising edge: rx_shift <= {rx_shift[FRAME_W-2:0], synced SDI1}. Bit counter increments and saturates at FRAME_W+1.
  - SHIFT, SCLK falling edge: if count < FRAME_W, tx_shift shifts left and SDO1 takes the new MSB; otherwise SDO1=0. SDO1 changes ≤ 3 CLK after the raw SCLK fall.
  - SHIFT, synced SYNC1 rising edge: return to IDLE, SDO1=0.
    - If count == FRAME_W: CMD_OUT <= rx_shift and CMD_VALID pulses for 1 CLK on the cycle after the edge. If rx_shift[15]==1, CH_SEL <= rx_shift[14:12] on that same cycle; otherwise CH_SEL is unchanged.
    - If count != FRAME_W (short frame, or more than 16 edges): FRAME_ERR pulses for 1 CLK. CMD_OUT and CH_SEL are unchanged.
- Pipelining: a CH_SEL change takes effect from the next frame. The frame that carries the write command returns data for the previous channel.
- Simultaneous events: if a SYNC1 rise and an SCLK edge are detected on the same CLK, the SYNC1 rise wins and the SCLK edge is ignored.
- An SCLK edge while in IDLE or WAIT_HIGH is ignored.
- Asynchronous reset mid-frame: all outputs go to their reset values immediately. The frame is discarded and the FSM re-enters WAIT_HIGH.
- CMD_VALID and FRAME_ERR are never asserted together.

Test Plan:
- Reset, then SYNC1 high, CH_SEL=0, SAMPLE_IN=12'hABC, 16-clock frame with SDI1 word 16'h0000 → SDO1 serializes 16'h0ABC MSB first. CMD_OUT=16'h0000, one CMD_VALID pulse, CH_SEL stays 0.
- Frame with SDI1=16'hD000 (write, channel 5), SAMPLE_IN=12'h123 → this frame returns 16'h0123. CH_SEL=5 after SYNC1 rises. Next frame with SAMPLE_IN=12'h456 returns 16'h5456.
- Frame with SDI1=16'h3000 (bit15=0) → CMD_OUT=16'h3000, CMD_VALID pulses, CH_SEL unchanged.
- Short frame (10 SCLK edges) and long frame (18 edges) → FRAME_ERR pulses once each, with no CMD_VALID and CMD_OUT/CH_SEL unchanged. On the long frame, SDO1=0 after bit 16.
- RST_N low after bit 7 of a frame, released while SYNC1 is still low → outputs return to reset values. The remaining edges are ignored, with no CMD_VALID or FRAME_ERR. The next full frame after SYNC1 goes high works normally.
- SYNC1 rise coincident with a 16th SCLK rising edge at the synchronizer → the edge is ignored, count=15, and FRAME_ERR pulses.

Source files
------------

// File: rtl/adc_spi_responder.sv
// ADC-side SPI slave used to exercise the ADC SPI master without a real ADC.
// Oversamples SCLK/SYNC1/SDI1, receives a command frame, returns a tagged sample.
module adc_spi_responder #(
    parameter int FRAME_W = 16,
    parameter int DATA_W  = 12,
    parameter int CH_W    = 3
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               SCLK,
    input  logic               SYNC1,
    input  logic               SDI1,
    output logic               SDO1,
    input  logic [DATA_W-1:0]  SAMPLE_IN,
    output logic [CH_W-1:0]    CH_SEL,
    output logic [FRAME_W-1:0] CMD_OUT,
    output logic               CMD_VALID,
    output logic               FRAME_ERR
);

    localparam int CNT_W = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

    typedef enum logic [1:0] {
        WAIT_HIGH,
        IDLE,
        SHIFT
    } state_t;

    // Two-flop synchronizer stages plus a delayed copy for edge detection.
    // SYNC1 resets low so a frame already in progress is never seen as idle.
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic sync_meta_q, sync_sync_q, sync_prev_q;
    logic sdi_meta_q,  sdi_sync_q;

    // Edge strobes, derived only from the synchronized copies
    logic sclk_rise, sclk_fall;
    logic sync_rise, sync_fall;

    // Frame state
    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FRAME_W-1:0] rx_q;
    logic [FRAME_W-1:0] tx_q;
    logic [FRAME_W-1:0] tx_load;

    // Registered outputs
    logic               sdo_q;
    logic [CH_W-1:0]    ch_sel_q;
    logic [FRAME_W-1:0] cmd_q;
    logic               cmd_valid_q;
    logic               frame_err_q;

    // Synchronize the asynchronous SPI inputs into the CLK domain
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sync_meta_q <= 1'b0;
            sync_sync_q <= 1'b0;
            sdi_meta_q  <= 1'b0;
            sdi_sync_q  <= 1'b0;
        end else begin
            sclk_meta_q <= SCLK;
            sclk_sync_q <= sclk_meta_q;
            sync_meta_q <= SYNC1;
            sync_sync_q <= sync_meta_q;
            sdi_meta_q  <= SDI1;
            sdi_sync_q  <= sdi_meta_q;
        end
    end

    // Hold the previous synchronized level for edge detection
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_prev_q <= 1'b0;
            sync_prev_q <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_sync_q;
            sync_prev_q <= sync_sync_q;
        end
    end

    // Edge strobes and the word latched at frame start
    always_comb begin
        sclk_rise = sclk_sync_q & ~sclk_prev_q;
        sclk_fall = ~sclk_sync_q & sclk_prev_q;
        sync_rise = sync_sync_q & ~sync_prev_q;
        sync_fall = ~sync_sync_q & sync_prev_q;
        tx_load   = {1'b0, ch_sel_q, SAMPLE_IN};
    end

    // Frame FSM; a SYNC1 rise takes priority over a same-cycle SCLK edge
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= WAIT_HIGH;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            sdo_q       <= 1'b0;
            ch_sel_q    <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            unique case (state_q)
                WAIT_HIGH: begin
                    sdo_q <= 1'b0;
                    if (sync_sync_q) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    sdo_q <= 1'b0;
                    if (sync_fall) begin
                        tx_q    <= tx_load;
                        sdo_q   <= tx_load[FRAME_W-1];
                        rx_q    <= '0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sync_rise) begin
                        state_q <= IDLE;
                        sdo_q   <= 1'b0;
                        if (cnt_q == CNT_FULL) begin
                            cmd_q       <= rx_q;
                            cmd_valid_q <= 1'b1;
                            if (rx_q[FRAME_W-1]) begin
                                ch_sel_q <= rx_q[FRAME_W-2 -: CH_W];
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        rx_q <= {rx_q[FRAME_W-2:0], sdi_sync_q};
                        if (cnt_q != CNT_SAT) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (cnt_q < CNT_FULL) begin
                            tx_q  <= {tx_q[FRAME_W-2:0], 1'b0};
                            sdo_q <= tx_q[FRAME_W-2];
                        end else begin
                            sdo_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= WAIT_HIGH;
                    sdo_q   <= 1'b0;
                end
            endcase
        end
    end

    // Drive the ports from their registers
    always_comb begin
        SDO1      = sdo_q;
        CH_SEL    = ch_sel_q;
        CMD_OUT   = cmd_q;
        CMD_VALID = cmd_valid_q;
        FRAME_ERR = frame_err_q;
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder acting as the SPI master.
// Expected sample words are queued at frame start and compared at frame end.
module tb_adc_spi_responder;

    localparam int H = 5;

    logic        CLK;
    logic        RST_N;
    logic        SCLK;
    logic        SYNC1;
    logic        SDI1;
    logic        SDO1;
    logic [11:0] SAMPLE_IN;
    logic [2:0]  CH_SEL;
    logic [15:0] CMD_OUT;
    logic        CMD_VALID;
    logic        FRAME_ERR;

    int total = 0;
    int bad   = 0;
    int nv    = 0;
    int ne    = 0;
    int nboth = 0;

    logic [2:0]  m_ch;
    logic [15:0] m_cmd;
    logic [15:0] exp_q[$];

    adc_spi_responder dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .SCLK      (SCLK),
        .SYNC1     (SYNC1),
        .SDI1      (SDI1),
        .SDO1      (SDO1),
        .SAMPLE_IN (SAMPLE_IN),
        .CH_SEL    (CH_SEL),
        .CMD_OUT   (CMD_OUT),
        .CMD_VALID (CMD_VALID),
        .FRAME_ERR (FRAME_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pulse counters
    always @(negedge CLK) begin
        if (CMD_VALID) nv = nv + 1;
        if (FRAME_ERR) ne = ne + 1;
        if (CMD_VALID && FRAME_ERR) nboth = nboth + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One master frame of n SCLK pulses; optionally raise SYNC1 with the last rise
    task automatic run_frame(input string tag, input logic [15:0] cmd,
                             input int n, input logic [11:0] samp,
                             input bit coincide);
        int          v0;
        int          e0;
        int          eff;
        logic [15:0] got;
        logic [15:0] exp;
        bit          ok;
        got = '0;
        SAMPLE_IN = samp;
        exp_q.push_back({1'b0, m_ch, samp});
        v0 = nv;
        e0 = ne;
        SYNC1 = 1'b0;
        SDI1 = cmd[15];
        tick(H);
        for (int i = 0; i < n; i++) begin
            if (i < 16) got[15-i] = SDO1;
            else check({tag, "_sdo_tail"}, 32'(SDO1), 32'h0);
            SCLK = 1'b1;
            if (coincide && i == n - 1) SYNC1 = 1'b1;
            tick(H);
            SCLK = 1'b0;
            if (i + 1 < 16) SDI1 = cmd[14-i];
            else SDI1 = 1'b0;
            tick(H);
        end
        SYNC1 = 1'b1;
        tick(12);
        exp = exp_q.pop_front();
        if (n >= 16) check({tag, "_sdo"}, 32'(got), 32'(exp));
        else check({tag, "_sdo"}, 32'(got >> (16 - n)), 32'(exp >> (16 - n)));
        eff = coincide ? n - 1 : n;
        ok = (eff == 16);
        if (ok) begin
            m_cmd = cmd;
            if (cmd[15]) m_ch = cmd[14:12];
        end
        check({tag, "_valid"}, 32'(nv - v0), ok ? 32'd1 : 32'd0);
        check({tag, "_err"}, 32'(ne - e0), ok ? 32'd0 : 32'd1);
        check({tag, "_cmd"}, 32'(CMD_OUT), 32'(m_cmd));
        check({tag, "_ch"}, 32'(CH_SEL), 32'(m_ch));
    endtask

    initial begin
        int v0;
        int e0;
        RST_N = 1'b0;
        SCLK = 1'b0;
        SYNC1 = 1'b1;
        SDI1 = 1'b0;
        SAMPLE_IN = 12'h000;
        m_ch = 3'd0;
        m_cmd = 16'h0000;
        tick(3);
        check("rst_sdo", 32'(SDO1), 32'h0);
        check("rst_ch", 32'(CH_SEL), 32'h0);
        check("rst_cmd", 32'(CMD_OUT), 32'h0);
        check("rst_valid", 32'(CMD_VALID), 32'h0);
        check("rst_err", 32'(FRAME_ERR), 32'h0);
        RST_N = 1'b1;
        tick(6);

        run_frame("f0", 16'h0000, 16, 12'hABC, 1'b0);
        run_frame("wr5", 16'hD000, 16, 12'h123, 1'b0);
        run_frame("ch5", 16'h0000, 16, 12'h456, 1'b0);
        run_frame("rd3", 16'h3000, 16, 12'h789, 1'b0);
        run_frame("short", 16'hA5A5, 10, 12'h321, 1'b0);
        run_frame("long", 16'hB000, 18, 12'hFED, 1'b0);

        // Reset after bit 7, released while SYNC1 is still low
        v0 = nv;
        e0 = ne;
        SAMPLE_IN = 12'h55A;
        SYNC1 = 1'b0;
        SDI1 = 1'b1;
        tick(H);
        for (int i = 0; i < 7; i++) begin
            SCLK = 1'b1;
            tick(H);
            SCLK = 1'b0;
            tick(H);
        end
        RST_N = 1'b0;
        #1;
        check("mid_sdo", 32'(SDO1), 32'h0);
        check("mid_ch", 32'(CH_SEL), 32'h0);
        check("mid_cmd", 32'(CMD_OUT), 32'h0);
        check("mid_valid", 32'(CMD_VALID), 32'h0);
        check("mid_err", 32'(FRAME_ERR), 32'h0);
        m_ch = 3'd0;
        m_cmd = 16'h0000;
        tick(2);
        RST_N = 1'b1;
        for (int i = 7; i < 16; i++) begin
            check("mid_tail_sdo", 32'(SDO1), 32'h0);
            SCLK = 1'b1;
            tick(H);
            SCLK = 1'b0;
            tick(H);
        end
        SYNC1 = 1'b1;
        tick(12);
        check("mid_no_valid", 32'(nv - v0), 32'h0);
        check("mid_no_err", 32'(ne - e0), 32'h0);
        check("mid_cmd_after", 32'(CMD_OUT), 32'h0);

        run_frame("post", 16'h9000, 16, 12'h777, 1'b0);
        run_frame("post_ch1", 16'h0000, 16, 12'h0F0, 1'b0);
        run_frame("coinc", 16'hC000, 16, 12'h246, 1'b1);

        check("exclusive", 32'(nboth), 32'h0);
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
